// File: rtl/dvsd_8216m_pkg.sv
// Shared widths and elaboration-time helpers for the 8x8 Wallace-tree multiplier.
// Column heights are computed here so the reduction tree in the top module can be generated.
package dvsd_8216m_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  // Each column of height h keeps ceil(h/3) bits, from full adders, a half adder and a pass-through.
  function automatic int unsigned own_bits(int unsigned h);
    return (h + 2) / 3;
  endfunction

  // Each column of height h sends floor(h/3) full-adder carries, plus one half-adder carry when h%3 == 2.
  function automatic int unsigned carry_bits(int unsigned h);
    return (h / 3) + (((h % 3) == 2) ? 1 : 0);
  endfunction

  // Number of bits in column col after the given number of reduction stages.
  function automatic int unsigned col_height(int unsigned stage, int unsigned col);
    int unsigned h [PROD_W];
    int unsigned n [PROD_W];
    if (col >= PROD_W) return 0;
    for (int unsigned k = 0; k < PROD_W; k++) begin
      h[k] = (k < OP_W) ? (k + 1) : (2 * OP_W - 1 - k);
    end
    for (int unsigned t = 0; t < stage; t++) begin
      for (int unsigned k = 0; k < PROD_W; k++) begin
        n[k] = own_bits(h[k]);
        if (k > 0) n[k] = n[k] + carry_bits(h[k-1]);
      end
      h = n;
    end
    return h[col];
  endfunction

  function automatic int unsigned max_height(int unsigned stage);
    int unsigned m;
    m = 0;
    for (int unsigned c = 0; c < PROD_W; c++) begin
      if (col_height(stage, c) > m) m = col_height(stage, c);
    end
    return m;
  endfunction

  // Smallest stage count that leaves at most two rows for the final adder.
  function automatic int unsigned num_stages();
    int unsigned r;
    r = 8;
    for (int unsigned s = 8; s > 0; s--) begin
      if (max_height(s - 1) <= 2) r = s - 1;
    end
    return r;
  endfunction

  localparam int unsigned NUM_ST = num_stages();

endpackage

// File: rtl/dvsd_8216m_if.sv
// Operand/product bundle for the multiplier; the master drives operands and reads the product.
interface dvsd_8216m_if;
  import dvsd_8216m_pkg::*;

  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] m;

  modport master (output a, output b, input m);
  modport slave  (input a, input b, output m);
endinterface

// File: rtl/dvsd_csa32.sv
// 3:2 compressor (full adder) used throughout the reduction tree and the final ripple adder.
module dvsd_csa32 (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/dvsd_8216m.sv
// 8x8 unsigned Wallace-tree multiplier with a registered 16-bit product.
// Each reduction stage lives in its own generate block so stages are separate signals.
module dvsd_8216m
  import dvsd_8216m_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a0, a1, a2, a3, a4, a5, a6, a7,
  input  logic b0, b1, b2, b3, b4, b5, b6, b7,
  output logic m0,  m1,  m2,  m3,  m4,  m5,  m6,  m7,
  output logic m8,  m9,  m10, m11, m12, m13, m14, m15
);

  logic [OP_W-1:0]   a_op;
  logic [OP_W-1:0]   b_op;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] m_d;
  logic [PROD_W-1:0] m_q;

  assign a_op = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign b_op = {b7, b6, b5, b4, b3, b2, b1, b0};

  for (genvar s = 0; s <= NUM_ST; s++) begin : g_stg
    logic [PROD_W-1:0][OP_W-1:0] bits;
    logic                        unused_stage;
    assign unused_stage = ^bits;

    // Slots above the column height are tied off.
    for (genvar c = 0; c < PROD_W; c++) begin : g_col
      localparam int unsigned H = col_height(s, c);
      for (genvar k = 0; k < OP_W; k++) begin : g_tie
        if (k >= H) begin : g_zero
          assign bits[c][k] = 1'b0;
        end
      end
    end

    if (s == 0) begin : g_pp
      // Partial product a_i & b_j lands in column i+j; rows are packed from slot 0.
      for (genvar i = 0; i < OP_W; i++) begin : g_i
        for (genvar j = 0; j < OP_W; j++) begin : g_j
          localparam int unsigned K = ((i + j) < OP_W) ? i : (OP_W - 1 - j);
          assign bits[i+j][K] = a_op[i] & b_op[j];
        end
      end
    end else begin : g_red
      for (genvar c = 0; c < PROD_W; c++) begin : g_col
        localparam int unsigned HP  = col_height(s - 1, c);
        localparam int unsigned FA  = HP / 3;
        localparam int unsigned REM = HP % 3;
        localparam int unsigned OFF = own_bits(col_height(s - 1, c + 1));

        for (genvar f = 0; f < FA; f++) begin : g_fa
          logic fa_carry;
          dvsd_csa32 u_fa (
            .x     (g_stg[s-1].bits[c][3*f]),
            .y     (g_stg[s-1].bits[c][3*f+1]),
            .z     (g_stg[s-1].bits[c][3*f+2]),
            .sum   (bits[c][f]),
            .carry (fa_carry)
          );
          if (c < PROD_W - 1) begin : g_up
            assign bits[c+1][OFF+f] = fa_carry;
          end else begin : g_top
            // Weight 2^16 cannot be set by an 8x8 product.
            logic unused_carry;
            assign unused_carry = fa_carry;
          end
        end

        if (REM == 2) begin : g_ha
          logic ha_carry;
          assign bits[c][FA] = g_stg[s-1].bits[c][3*FA] ^ g_stg[s-1].bits[c][3*FA+1];
          assign ha_carry    = g_stg[s-1].bits[c][3*FA] & g_stg[s-1].bits[c][3*FA+1];
          if (c < PROD_W - 1) begin : g_up
            assign bits[c+1][OFF+FA] = ha_carry;
          end else begin : g_top
            logic unused_carry;
            assign unused_carry = ha_carry;
          end
        end else if (REM == 1) begin : g_pass
          assign bits[c][FA] = g_stg[s-1].bits[c][3*FA];
        end
      end
    end
  end

  // Final two rows are summed by a ripple-carry chain of compressors.
  for (genvar c = 0; c < PROD_W; c++) begin : g_rca
    logic cin;
    logic cout;
    if (c == 0) begin : g_c0
      assign cin = 1'b0;
    end else begin : g_cn
      assign cin = g_rca[c-1].cout;
    end
    dvsd_csa32 u_fa (
      .x     (g_stg[NUM_ST].bits[c][0]),
      .y     (g_stg[NUM_ST].bits[c][1]),
      .z     (cin),
      .sum   (prod_c[c]),
      .carry (cout)
    );
    if (c == PROD_W - 1) begin : g_msb
      logic unused_cout;
      assign unused_cout = cout;
    end
  end

  always_comb begin
    m_d = prod_c;
  end

  always_ff @(posedge clk) begin
    if (reset) m_q <= '0;
    else       m_q <= m_d;
  end

  assign {m15, m14, m13, m12, m11, m10, m9, m8, m7, m6, m5, m4, m3, m2, m1, m0} = m_q;

endmodule

// File: tb/tb_dvsd_8216m.sv
// Directed and random checks of the registered 8x8 multiplier against hand-computed products.
module tb_dvsd_8216m;
  import dvsd_8216m_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  dvsd_8216m_if bus ();

  always #5 clk = ~clk;

  dvsd_8216m dut (
    .clk   (clk),
    .reset (reset),
    .a0 (bus.a[0]), .a1 (bus.a[1]), .a2 (bus.a[2]), .a3 (bus.a[3]),
    .a4 (bus.a[4]), .a5 (bus.a[5]), .a6 (bus.a[6]), .a7 (bus.a[7]),
    .b0 (bus.b[0]), .b1 (bus.b[1]), .b2 (bus.b[2]), .b3 (bus.b[3]),
    .b4 (bus.b[4]), .b5 (bus.b[5]), .b6 (bus.b[6]), .b7 (bus.b[7]),
    .m0  (bus.m[0]),  .m1  (bus.m[1]),  .m2  (bus.m[2]),  .m3  (bus.m[3]),
    .m4  (bus.m[4]),  .m5  (bus.m[5]),  .m6  (bus.m[6]),  .m7  (bus.m[7]),
    .m8  (bus.m[8]),  .m9  (bus.m[9]),  .m10 (bus.m[10]), .m11 (bus.m[11]),
    .m12 (bus.m[12]), .m13 (bus.m[13]), .m14 (bus.m[14]), .m15 (bus.m[15])
  );

  task automatic check(input string tag, input logic [PROD_W-1:0] exp);
    vectors++;
    assert (bus.m === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, bus.m, exp);
    end
  endtask

  // Called at a falling edge: drive operands, let one rising edge load them, check at the next fall.
  task automatic step(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      input logic [PROD_W-1:0] exp, input string tag);
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    check(tag, exp);
  endtask

  initial begin
    logic [OP_W-1:0] ra;
    logic [OP_W-1:0] rb;

    reset = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 16'h0000);

    reset = 1'b0;
    step(8'h00, 8'h00, 16'h0000, "zero");
    step(8'hFF, 8'hFF, 16'hFE01, "max");
    step(8'hFF, 8'h01, 16'h00FF, "ff_x_01");
    step(8'h00, 8'h5A, 16'h0000, "a_zero");
    step(8'hA5, 8'h00, 16'h0000, "b_zero");
    step(8'h01, 8'hAB, 16'h00AB, "identity");
    step(8'h80, 8'h80, 16'h4000, "msb_x_msb");
    step(8'h0F, 8'h11, 16'h00FF, "0f_x_11");

    step(8'h12, 8'h34, 16'h03A8, "latency_n");
    bus.a = 8'h56;
    bus.b = 8'h78;
    #1;
    check("no_comb_path", 16'h03A8);
    @(posedge clk);
    @(negedge clk);
    check("latency_n1", 16'h2850);

    bus.a = 8'hC3;
    bus.b = 8'h5A;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset", 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("after_reset", 16'h448E);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(ra, rb, 16'(ra) * 16'(rb), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
